// File: rtl/e_mdu_if.sv
// ---------------------------------------------------------------------------
// e_mdu_if : operand / result bundle between the E stage and the multiply-
// divide unit.
//   E_V1, E_V2  forwarded rs / rt operand values
//   E_MDUOp     operation select (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//               5 mthi, 6 mtlo, 7 reserved)
//   E_Start     an arithmetic operation is being accepted this cycle
//   E_Busy      an arithmetic operation is in flight
//   E_HI, E_LO  committed architectural HI / LO registers
// master: the pipeline side that drives operands; slave: the MDU.
// ---------------------------------------------------------------------------
interface e_mdu_if;
    logic [31:0] E_V1;
    logic [31:0] E_V2;
    logic [2:0]  E_MDUOp;
    logic        E_Start;
    logic        E_Busy;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    modport master (
        output E_V1, E_V2, E_MDUOp,
        input  E_Start, E_Busy, E_HI, E_LO
    );

    modport slave (
        input  E_V1, E_V2, E_MDUOp,
        output E_Start, E_Busy, E_HI, E_LO
    );
endinterface

// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu : execute-stage multiply/divide unit holding the HI/LO registers.
// The result is computed combinationally when the operation is accepted,
// parked in temp_hi/temp_lo, and committed to HI/LO once the modelled
// latency (MULT_CYCLES or DIV_CYCLES) has elapsed.
//   clk    single clock, rising edge
//   reset  synchronous, active-low; clears all state
//   mdu    e_mdu_if.slave (operands, op select, start/busy, HI/LO)
// ---------------------------------------------------------------------------
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    e_mdu_if.slave     mdu
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]      r_hi, w_hi_nxt;
    logic [31:0]      r_lo, w_lo_nxt;
    logic [31:0]      r_temp_hi, w_temp_hi_nxt;
    logic [31:0]      r_temp_lo, w_temp_lo_nxt;
    logic             r_div0, w_div0_nxt;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_quot_mag;
    logic [31:0] w_rem_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Products: operands explicitly widened so the multiply is done at 64 bits.
    assign w_prod_s = $signed({{32{mdu.E_V1[31]}}, mdu.E_V1}) *
                      $signed({{32{mdu.E_V2[31]}}, mdu.E_V2});
    assign w_prod_u = {32'd0, mdu.E_V1} * {32'd0, mdu.E_V2};

    // Division works on magnitudes and fixes signs afterwards. The magnitude
    // of 0x80000000 is representable unsigned, so 0x80000000 / -1 naturally
    // yields quotient 0x80000000, remainder 0. A zero divisor is replaced by 1
    // only to keep the divider defined; that result is never committed.
    assign w_signed   = (mdu.E_MDUOp == 3'd3);
    assign w_a_neg    = w_signed & mdu.E_V1[31];
    assign w_b_neg    = w_signed & mdu.E_V2[31];
    assign w_a_mag    = w_a_neg ? (32'd0 - mdu.E_V1) : mdu.E_V1;
    assign w_b_mag    = w_b_neg ? (32'd0 - mdu.E_V2) : mdu.E_V2;
    assign w_b_safe   = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_quot_mag = w_a_mag / w_b_safe;
    assign w_rem_mag  = w_a_mag % w_b_safe;
    assign w_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_quot_mag) : w_quot_mag;
    assign w_rem      = w_a_neg ? (32'd0 - w_rem_mag) : w_rem_mag;

    assign mdu.E_Start = (r_state == S_IDLE) &&
                         (mdu.E_MDUOp >= 3'd1) && (mdu.E_MDUOp <= 3'd4);
    assign mdu.E_Busy  = (r_state == S_RUN);
    assign mdu.E_HI    = r_hi;
    assign mdu.E_LO    = r_lo;

    // Next-state logic: accept ops only in IDLE, count down and commit in RUN.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_temp_hi_nxt = r_temp_hi;
        w_temp_lo_nxt = r_temp_lo;
        w_div0_nxt    = r_div0;
        case (r_state)
            S_IDLE: begin
                case (mdu.E_MDUOp)
                    3'd1: begin
                        w_temp_hi_nxt = w_prod_s[63:32];
                        w_temp_lo_nxt = w_prod_s[31:0];
                        w_cnt_nxt     = CNT_W'(MULT_CYCLES);
                        w_div0_nxt    = 1'b0;
                        w_state_nxt   = S_RUN;
                    end
                    3'd2: begin
                        w_temp_hi_nxt = w_prod_u[63:32];
                        w_temp_lo_nxt = w_prod_u[31:0];
                        w_cnt_nxt     = CNT_W'(MULT_CYCLES);
                        w_div0_nxt    = 1'b0;
                        w_state_nxt   = S_RUN;
                    end
                    3'd3, 3'd4: begin
                        w_temp_hi_nxt = w_rem;
                        w_temp_lo_nxt = w_quot;
                        w_cnt_nxt     = CNT_W'(DIV_CYCLES);
                        w_div0_nxt    = (mdu.E_V2 == 32'd0);
                        w_state_nxt   = S_RUN;
                    end
                    3'd5: w_hi_nxt = mdu.E_V1;
                    3'd6: w_lo_nxt = mdu.E_V1;
                    default: ;
                endcase
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                // <= 1 rather than == 1 so a corrupted zero count still exits.
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_W'(0);
                    if (!r_div0) begin
                        w_hi_nxt = r_temp_hi;
                        w_lo_nxt = r_temp_lo;
                    end else begin
                        w_hi_nxt = r_hi;
                        w_lo_nxt = r_lo;
                    end
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CNT_W'(0);
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= CNT_W'(0);
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_temp_hi <= 32'd0;
            r_temp_lo <= 32'd0;
            r_div0    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_temp_hi <= w_temp_hi_nxt;
            r_temp_lo <= w_temp_lo_nxt;
            r_div0    <= w_div0_nxt;
        end
    end
endmodule

// File: tb/tb_e_mdu.sv
// ---------------------------------------------------------------------------
// tb_e_mdu : directed plus randomized self-checking bench for e_mdu.
// Expected HI/LO come from a 64-bit arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_e_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    e_mdu_if mdu();

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mdu.slave)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    // Reference model: returns {hi, lo} after the operation completes.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        logic [63:0]     res;
        res = {hi, lo};
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (op)
            3'd1: begin p = sa * sb; res = p; end
            3'd2: begin up = ua * ub; res = up; end
            3'd3: if (b != 32'd0) begin
                      q = sa / sb;
                      r = sa % sb;
                      res = {r[31:0], q[31:0]};
                  end
            3'd4: if (b != 32'd0) begin
                      up = ua / ub;
                      res[31:0] = up[31:0];
                      up = ua % ub;
                      res[63:32] = up[31:0];
                  end
            default: ;
        endcase
        return res;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_arch(input string tag);
        check({tag, "_hi"}, mdu.E_HI, m_hi);
        check({tag, "_lo"}, mdu.E_LO, m_lo);
    endtask

    // Arithmetic op: random ops are driven while busy; they must all be ignored.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          n;
        logic [63:0] res;
        n = (op <= 3'd2) ? MC : DC;
        res = model(op, a, b, m_hi, m_lo);
        mdu.E_MDUOp = op;
        mdu.E_V1    = a;
        mdu.E_V2    = b;
        #1;
        check("start", 32'(mdu.E_Start), 32'd1);
        tick;
        for (int i = 0; i < n; i++) begin
            mdu.E_MDUOp = 3'($urandom_range(0, 7));
            mdu.E_V1    = $urandom;
            mdu.E_V2    = $urandom;
            #1;
            check("busy", 32'(mdu.E_Busy), 32'd1);
            check("start_blocked", 32'(mdu.E_Start), 32'd0);
            check_arch("hold");
            tick;
        end
        mdu.E_MDUOp = 3'd0;
        #1;
        m_hi = res[63:32];
        m_lo = res[31:0];
        check("busy_done", 32'(mdu.E_Busy), 32'd0);
        check_arch("commit");
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        mdu.E_MDUOp = op;
        mdu.E_V1    = v;
        mdu.E_V2    = $urandom;
        #1;
        check("mt_start", 32'(mdu.E_Start), 32'd0);
        tick;
        mdu.E_MDUOp = 3'd0;
        if (op == 3'd5) m_hi = v;
        else            m_lo = v;
        check("mt_busy", 32'(mdu.E_Busy), 32'd0);
        check_arch("mt");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset       = 1'b0;
        mdu.E_MDUOp = 3'd0;
        mdu.E_V1    = 32'd0;
        mdu.E_V2    = 32'd0;
        tick;
        tick;
        reset = 1'b1;
        check("rst_busy", 32'(mdu.E_Busy), 32'd0);
        check("rst_start", 32'(mdu.E_Start), 32'd0);
        check_arch("rst");

        // Directed arithmetic cases.
        run_md(3'd1, 32'hFFFFFFFE, 32'h00000003);
        check("mult_hi_const", mdu.E_HI, 32'hFFFFFFFF);
        check("mult_lo_const", mdu.E_LO, 32'hFFFFFFFA);
        run_md(3'd2, 32'hFFFFFFFE, 32'h00000003);
        check("multu_hi_const", mdu.E_HI, 32'h00000002);
        run_md(3'd3, 32'hFFFFFFF9, 32'd2);
        check("div_lo_const", mdu.E_LO, 32'hFFFFFFFD);
        check("div_hi_const", mdu.E_HI, 32'hFFFFFFFF);
        run_md(3'd4, 32'd7, 32'd2);
        run_md(3'd3, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_lo", mdu.E_LO, 32'h80000000);

        // Divide by zero keeps the previously written HI/LO.
        mt(3'd5, 32'h12345678);
        mt(3'd6, 32'h9ABCDEF0);
        run_md(3'd3, 32'd5, 32'd0);
        check("div0_hi", mdu.E_HI, 32'h12345678);
        run_md(3'd4, 32'd5, 32'd0);

        // Ignored ops during a mult, then back-to-back div.
        run_md(3'd1, 32'd3, 32'd4);
        check("mult34_lo", mdu.E_LO, 32'd12);
        run_md(3'd3, 32'd100, 32'd7);
        check("div100_lo", mdu.E_LO, 32'd14);
        check("div100_hi", mdu.E_HI, 32'd2);

        // None and reserved ops in IDLE change nothing.
        for (int i = 0; i < 2; i++) begin
            mdu.E_MDUOp = (i == 0) ? 3'd0 : 3'd7;
            mdu.E_V1    = $urandom;
            #1;
            check("idle_start", 32'(mdu.E_Start), 32'd0);
            tick;
            check("idle_busy", 32'(mdu.E_Busy), 32'd0);
            check_arch("idle");
        end
        mdu.E_MDUOp = 3'd0;

        // Reset in the middle of a div aborts it without commit.
        mt(3'd5, 32'hAAAA5555);
        mt(3'd6, 32'h5555AAAA);
        mdu.E_MDUOp = 3'd3;
        mdu.E_V1    = 32'd100;
        mdu.E_V2    = 32'd3;
        tick;
        mdu.E_MDUOp = 3'd0;
        tick;
        tick;
        reset = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        check("rst_mid_busy", 32'(mdu.E_Busy), 32'd0);
        check_arch("rst_mid");
        for (int i = 0; i < DC + 2; i++) begin
            tick;
            check("rst_nocommit_busy", 32'(mdu.E_Busy), 32'd0);
            check_arch("rst_nocommit");
        end

        // Randomized operations.
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(1, 6));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000000F;
            if (rop >= 3'd5) mt(rop, ra);
            else             run_md(rop, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
